// File: rtl/sym_vn_lut_loader_if.sv
// sym_vn_lut_loader_if
// Bundles the loader's entry stream (valid/ready) and the symmetric VN
// IB-LUT write port into one interface.
//   master : the loader. It takes in the entry stream and drives entry_ready
//            and the LUT write port.
//   slave  : the environment. It is the entry source and the LUT write sink.
// Signals:
//   entry_in / entry_valid / entry_ready : serial LUT entry handshake
//   lut_in_bank0 / lut_in_bank1          : even/odd entry of the current page
//   page_write_addr                      : page being written
//   write_addr_offset                    : target frame slot
//   we                                   : one-cycle write strobe per page
interface sym_vn_lut_loader_if #(
  parameter int LUT_PORT_SIZE = 3,
  parameter int PAGE_W        = 4
);
  logic [LUT_PORT_SIZE-1:0] entry_in;
  logic                     entry_valid;
  logic                     entry_ready;
  logic [LUT_PORT_SIZE-1:0] lut_in_bank0;
  logic [LUT_PORT_SIZE-1:0] lut_in_bank1;
  logic [PAGE_W-1:0]        page_write_addr;
  logic                     write_addr_offset;
  logic                     we;

  modport master (
    input  entry_in, entry_valid,
    output entry_ready, lut_in_bank0, lut_in_bank1,
           page_write_addr, write_addr_offset, we
  );

  modport slave (
    output entry_in, entry_valid,
    input  entry_ready, lut_in_bank0, lut_in_bank1,
           page_write_addr, write_addr_offset, we
  );
endinterface

// File: rtl/sym_vn_lut_loader.sv
// sym_vn_lut_loader
// Write-side controller for the symmetric VN IB-LUT. It takes a serial stream
// of LUT entries and pairs them into bank0/bank1 words, with the even entry
// first. It issues one write pulse per page, walks every page of one frame
// slot, and then pulses load_done. It runs entirely in the write_clk domain.
// Ports:
//   write_clk   : write-domain clock, rising edge
//   rstn        : synchronous active-low reset
//   load_start  : request to load one slot (seen only while idle)
//   load_offset : target frame slot, latched when a start is accepted
//   busy        : load in progress (collecting or writing)
//   load_done   : one-cycle pulse after the last page write
//   lut_if      : entry stream + LUT write port (master side)
// Optional build macro SYM_VN_LOADER_PARITY_EN adds these ports:
//   entry_parity : even parity over entry_in
//   err_clr      : clears parity_err
//   parity_err   : sticky flag, set on a handshake with bad parity
module sym_vn_lut_loader #(
  parameter int QUAN_SIZE       = 3,
  parameter int LUT_PORT_SIZE   = 3,
  parameter int ENTRY_ADDR      = 5,
  parameter int MULTI_FRAME_NUM = 2
) (
  input  logic                 write_clk,
  input  logic                 rstn,
  input  logic                 load_start,
  input  logic                 load_offset,
`ifdef SYM_VN_LOADER_PARITY_EN
  input  logic                 entry_parity,
  input  logic                 err_clr,
  output logic                 parity_err,
`endif
  output logic                 busy,
  output logic                 load_done,
  sym_vn_lut_loader_if.master  lut_if
);
  localparam int PAGE_W = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM);
  localparam logic [PAGE_W-1:0] LAST_PAGE = '1;

  typedef enum logic [2:0] {IDLE, COL_LO, COL_HI, WR, DONE} state_t;

  state_t                   state, state_nxt;
  logic [PAGE_W-1:0]        page_cnt;
  logic [PAGE_W-1:0]        page_addr_q;
  logic [LUT_PORT_SIZE-1:0] bank0_q, bank1_q;
  logic                     offset_q;
  logic                     ready;
  logic                     hs;

  assign hs = ready & lut_if.entry_valid;

  always_ff @(posedge write_clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Every control output is a decode of the state register.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    lut_if.we = 1'b0;
    load_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) state_nxt = COL_LO;
      end
      COL_LO: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (hs) state_nxt = COL_HI;
      end
      COL_HI: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (hs) state_nxt = WR;
      end
      WR: begin
        busy      = 1'b1;
        lut_if.we = 1'b1;
        state_nxt = (page_cnt == LAST_PAGE) ? DONE : COL_LO;
      end
      DONE: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // page_write_addr is loaded together with bank1. This makes it equal
  // page_cnt for the whole WR cycle and hold that value afterwards.
  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      page_cnt    <= '0;
      page_addr_q <= '0;
      bank0_q     <= '0;
      bank1_q     <= '0;
      offset_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (load_start) begin
          offset_q <= load_offset;
          page_cnt <= '0;
        end
        COL_LO: if (hs) bank0_q <= lut_if.entry_in;
        COL_HI: if (hs) begin
          bank1_q     <= lut_if.entry_in;
          page_addr_q <= page_cnt;
        end
        WR: if (page_cnt != LAST_PAGE) page_cnt <= page_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign lut_if.entry_ready       = ready;
  assign lut_if.lut_in_bank0      = bank0_q;
  assign lut_if.lut_in_bank1      = bank1_q;
  assign lut_if.page_write_addr   = page_addr_q;
  assign lut_if.write_addr_offset = offset_q;

`ifdef SYM_VN_LOADER_PARITY_EN
  // A mismatch seen in the same cycle as err_clr still sets the flag.
  always_ff @(posedge write_clk) begin
    if (!rstn)                                          parity_err <= 1'b0;
    else if (hs && (entry_parity != ^lut_if.entry_in))  parity_err <= 1'b1;
    else if (err_clr)                                   parity_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
`timescale 1ns/1ps
module tb_sym_vn_lut_loader;
  localparam int LPS   = 3;
  localparam int PW    = 4;
  localparam int N_ENT = 2 * (1 << PW);

  logic write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  logic rstn, load_start, load_offset, busy, load_done;
`ifdef SYM_VN_LOADER_PARITY_EN
  logic entry_parity, err_clr, parity_err;
`endif

  sym_vn_lut_loader_if #(.LUT_PORT_SIZE(LPS), .PAGE_W(PW)) bus ();

  sym_vn_lut_loader #(
    .QUAN_SIZE(3), .LUT_PORT_SIZE(LPS), .ENTRY_ADDR(5), .MULTI_FRAME_NUM(2)
  ) dut (
    .write_clk   (write_clk),
    .rstn        (rstn),
    .load_start  (load_start),
    .load_offset (load_offset),
`ifdef SYM_VN_LOADER_PARITY_EN
    .entry_parity(entry_parity),
    .err_clr     (err_clr),
    .parity_err  (parity_err),
`endif
    .busy        (busy),
    .load_done   (load_done),
    .lut_if      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model, expressed in terms of the entry stream: the number of
  // entries accepted so far decides the bank, the page and when a write is due.
  logic            m_busy = 0, m_we = 0, m_done = 0, m_off = 0, m_perr = 0;
  int unsigned     m_idx = 0;
  logic [PW-1:0]   m_page = '0;
  logic [LPS-1:0]  m_b0 = '0, m_b1 = '0;

  task automatic step(input logic r, input logic s, input logic o, input logic v,
                      input logic [LPS-1:0] e, input logic bad_par = 1'b0,
                      input logic clr = 1'b0);
    logic n_busy, n_we, n_done, n_off, n_perr, rdy, hs_m;
    int unsigned n_idx;
    logic [PW-1:0] n_page;
    logic [LPS-1:0] n_b0, n_b1;
    @(negedge write_clk);
    rstn = r; load_start = s; load_offset = o;
    bus.entry_valid = v; bus.entry_in = e;
`ifdef SYM_VN_LOADER_PARITY_EN
    entry_parity = (^e) ^ bad_par; err_clr = clr;
`endif
    rdy  = m_busy && !m_we;
    hs_m = rdy && v;
    n_busy = m_busy; n_we = 1'b0; n_done = 1'b0; n_off = m_off; n_perr = m_perr;
    n_idx = m_idx; n_page = m_page; n_b0 = m_b0; n_b1 = m_b1;
    if (!r) begin
      n_busy = 0; n_off = 0; n_perr = 0; n_page = '0; n_b0 = '0; n_b1 = '0;
    end else begin
      if (hs_m && bad_par) n_perr = 1'b1;
      else if (clr)        n_perr = 1'b0;
      if (m_done) begin
        // returning to idle; any start here is dropped
      end else if (!m_busy) begin
        if (s) begin n_busy = 1'b1; n_off = o; n_idx = 0; end
      end else if (m_we) begin
        if (m_idx == N_ENT) begin n_busy = 1'b0; n_done = 1'b1; end
      end else if (v) begin
        if (m_idx % 2 == 0) n_b0 = e; else n_b1 = e;
        n_idx = m_idx + 1;
        if (n_idx % 2 == 0) begin n_we = 1'b1; n_page = PW'(n_idx / 2 - 1); end
      end
    end
    @(posedge write_clk);
    #1;
    m_busy = n_busy; m_we = n_we; m_done = n_done; m_off = n_off; m_perr = n_perr;
    m_idx = n_idx; m_page = n_page; m_b0 = n_b0; m_b1 = n_b1;
    chk("ready", 32'(bus.entry_ready), 32'(m_busy && !m_we));
    chk("busy",  32'(busy),  32'(m_busy));
    chk("we",    32'(bus.we), 32'(m_we));
    chk("done",  32'(load_done), 32'(m_done));
    chk("off",   32'(bus.write_addr_offset), 32'(m_off));
    chk("page",  32'(bus.page_write_addr), 32'(m_page));
    chk("bank0", 32'(bus.lut_in_bank0), 32'(m_b0));
    chk("bank1", 32'(bus.lut_in_bank1), 32'(m_b1));
`ifdef SYM_VN_LOADER_PARITY_EN
    chk("perr",  32'(parity_err), 32'(m_perr));
`endif
  endtask

  typedef struct {
    logic rstn, start, off, valid;
    logic [LPS-1:0] ent;
    logic e_ready, e_busy, e_we, e_done, e_off;
    logic [PW-1:0] e_page;
    logic [LPS-1:0] e_b0, e_b1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int unsigned cyc, we_cnt, pexp;
    logic inj, s;
    rstn = 1'b0; load_start = 1'b0; load_offset = 1'b0;
    bus.entry_valid = 1'b0; bus.entry_in = '0;
`ifdef SYM_VN_LOADER_PARITY_EN
    entry_parity = 1'b0; err_clr = 1'b0;
`endif
    //          rstn st  off vld ent   rdy  busy we   done off  page  b0    b1
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,3'd0,3'd0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,3'd0,3'd0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,3'd0,3'd0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,3'd0,3'd0};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,3'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,4'd0,3'd0,3'd0};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,3'd5, 1'b1,1'b1,1'b0,1'b0,1'b1,4'd0,3'd5,3'd0};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,3'd5, 1'b1,1'b1,1'b0,1'b0,1'b1,4'd0,3'd5,3'd0};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,3'd2, 1'b0,1'b1,1'b1,1'b0,1'b1,4'd0,3'd5,3'd2};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b1,3'd7, 1'b1,1'b1,1'b0,1'b0,1'b1,4'd0,3'd5,3'd2};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b1,3'd7, 1'b1,1'b1,1'b0,1'b0,1'b1,4'd0,3'd7,3'd2};
    tbl[10] = '{1'b1,1'b1,1'b0,1'b1,3'd1, 1'b0,1'b1,1'b1,1'b0,1'b1,4'd1,3'd7,3'd1};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,3'd0,3'd0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rstn, tbl[i].start, tbl[i].off, tbl[i].valid, tbl[i].ent);
      chk("tbl_ready", 32'(bus.entry_ready), 32'(tbl[i].e_ready));
      chk("tbl_busy",  32'(busy), 32'(tbl[i].e_busy));
      chk("tbl_we",    32'(bus.we), 32'(tbl[i].e_we));
      chk("tbl_done",  32'(load_done), 32'(tbl[i].e_done));
      chk("tbl_off",   32'(bus.write_addr_offset), 32'(tbl[i].e_off));
      chk("tbl_page",  32'(bus.page_write_addr), 32'(tbl[i].e_page));
      chk("tbl_b0",    32'(bus.lut_in_bank0), 32'(tbl[i].e_b0));
      chk("tbl_b1",    32'(bus.lut_in_bank1), 32'(tbl[i].e_b1));
    end

    // Full load, entries e%8, with a stray start (offset 0) during page 5.
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    cyc = 0; we_cnt = 0; pexp = 0; inj = 1'b0;
    while (!m_done && cyc < 200) begin
      s = 1'b0;
      if (!inj && m_idx == 10 && m_busy && !m_we) begin s = 1'b1; inj = 1'b1; end
      step(1, s, 1'b0, 1, LPS'(m_idx % 8));
      if (bus.we) begin
        chk("fl_page", 32'(bus.page_write_addr), pexp);
        chk("fl_b0", 32'(bus.lut_in_bank0), (2 * pexp) % 8);
        chk("fl_b1", 32'(bus.lut_in_bank1), (2 * pexp + 1) % 8);
        chk("fl_off", 32'(bus.write_addr_offset), 1);
        we_cnt++; pexp++;
      end
      cyc++;
    end
    chk("fl_in_time", 32'(cyc < 200), 1);
    chk("fl_we_cnt", we_cnt, 16);
    chk("fl_done", 32'(load_done), 1);
    chk("fl_busy_done", 32'(busy), 0);
    step(1, 1, 0, 0, 0);              // start during DONE is dropped
    chk("done_start_ign", 32'(busy), 0);
    step(1, 0, 0, 0, 0);
    chk("idle_after_done", 32'(bus.entry_ready), 0);

    // Backpressure: valid pattern 1,0,0,1.
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 3'd4);
    step(1, 0, 0, 0, 3'd4);
    chk("bp_gap_we", 32'(bus.we), 0);
    chk("bp_gap_ready", 32'(bus.entry_ready), 1);
    step(1, 0, 0, 0, 3'd4);
    chk("bp_gap2_we", 32'(bus.we), 0);
    step(1, 0, 0, 1, 3'd6);
    chk("bp_we", 32'(bus.we), 1);
    chk("bp_b0", 32'(bus.lut_in_bank0), 4);
    chk("bp_b1", 32'(bus.lut_in_bank1), 6);

    // Reset during COL_HI of page 7, then reload from page 0.
    cyc = 0;
    while (!(m_idx == 15 && !m_we) && cyc < 100) begin
      step(1, 0, 0, 1, LPS'($urandom_range(7)));
      cyc++;
    end
    chk("rm_reach", 32'(cyc < 100), 1);
    chk("rm_page6", 32'(bus.page_write_addr), 6);
    step(0, 0, 0, 1, 3'd3);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_we", 32'(bus.we), 0);
    step(1, 0, 0, 1, 3'd3);
    chk("rm_idle_we", 32'(bus.we), 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 1, 3'd2);
    step(1, 0, 0, 1, 3'd5);
    chk("rl_we", 32'(bus.we), 1);
    chk("rl_page", 32'(bus.page_write_addr), 0);

    // Randomised loads with random valid gaps and stray starts.
    for (int l = 0; l < 4; l++) begin
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 1'($urandom_range(1)), 0, 0);
      cyc = 0;
      while (!m_done && cyc < 400) begin
        step(1, 1'($urandom_range(9) == 0), 1'($urandom_range(1)),
             1'($urandom_range(9) < 6), LPS'($urandom_range(7)));
        cyc++;
      end
      chk("rnd_in_time", 32'(cyc < 400), 1);
    end

`ifdef SYM_VN_LOADER_PARITY_EN
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 3'd3, 1'b1);     // 0x3 with parity 1: mismatch
    chk("par_set", 32'(parity_err), 1);
    step(1, 0, 0, 1, 3'd1);
    chk("par_sticky", 32'(parity_err), 1);
    step(1, 0, 0, 0, 0, 1'b0, 1'b1);
    chk("par_clr", 32'(parity_err), 0);
    step(1, 0, 0, 1, 3'd6, 1'b1, 1'b1);
    chk("par_set_prio", 32'(parity_err), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sym_vn_lut_loader.md
Name: sym_vn_lut_loader

Overview:
Write-side controller feeding the symmetric VN IB-LUT write port (lut_in_bank0/1, page_write_addr, write_addr_offset, we).
- Accepts a serial stream of LUT entries over a valid/ready handshake.
- Pairs consecutive entries into bank0/bank1 words and issues one write pulse per page.
- Walks all pages of one frame slot, then signals completion.
- Used to reload IB-LUTs between iterations/frames without stalling the read pipeline. The read pipeline runs on its own clock.

Parameters:
QUAN_SIZE, 3, message quantisation width
LUT_PORT_SIZE, 3, width of one LUT entry
ENTRY_ADDR, 5, log2 of total entries per LUT slot set
MULTI_FRAME_NUM, 2, number of frame slots; PAGE_W = ENTRY_ADDR-$clog2(MULTI_FRAME_NUM) (default 4, i.e. 16 pages)

Ports:
write_clk  in  1  write-domain clock, rising edge
rstn  in  1  synchronous active-low reset
load_start  in  1  one-cycle request to begin loading one LUT slot
load_offset  in  1  target frame slot, latched on accepted start
entry_in  in  LUT_PORT_SIZE  LUT entry data
entry_valid  in  1  entry_in is valid
entry_ready  out  1  loader accepts entry this cycle
lut_in_bank0  out  LUT_PORT_SIZE  even entry of the current page
lut_in_bank1  out  LUT_PORT_SIZE  odd entry of the current page
page_write_addr  out  PAGE_W  page being written
write_addr_offset  out  1  latched load_offset
we  out  1  write strobe, one cycle per page
busy  out  1  load in progress
load_done  out  1  one-cycle pulse after the last page write

Behaviour:
- All state updates on posedge write_clk.
- rstn=0 (sampled) forces state IDLE. All outputs go to 0 and page_cnt=0, including when reset hits mid-load; a partial load is abandoned with no further we.
- Entry order: stream index e goes to page e>>1, bank e[0]. Bank0 is taken first.
- FSM states:
  - IDLE: entry_ready=0, busy=0. If load_start=1: latch load_offset into write_addr_offset, page_cnt<=0, go to COL_LO.
  - COL_LO: entry_ready=1, busy=1. On entry_valid&entry_ready, lut_in_bank0<=entry_in, go to COL_HI.
  - COL_HI: entry_ready=1. On handshake, lut_in_bank1<=entry_in, go to WR.
  - WR: entry_ready=0, we=1 for exactly this cycle, page_write_addr=page_cnt. If page_cnt==2^PAGE_W-1, go to DONE; else page_cnt<=page_cnt+1 and go to COL_LO.
  - DONE: load_done=1 for one cycle, busy=0, then go to IDLE.
- Outputs are registered and decoded from state. we and load_done are Moore outputs of WR and DONE.
- page_write_addr holds its last value outside WR. lut_in_bank0/1 hold their value until overwritten.
- Latency: the second entry handshake in cycle N gives we=1 in cycle N+1. Peak rate is one page every 3 cycles.
- load_start is ignored when not in IDLE, including in DONE. A start in IDLE on the same cycle as the DONE->IDLE transition is not seen; it must be asserted while in IDLE.
- entry_valid while entry_ready=0 is not consumed. The source must hold entry_in/entry_valid until the handshake.
- page_cnt never wraps within a load. The terminal check prevents overflow.

Optional Feature:
SYM_VN_LOADER_PARITY_EN
- With the macro: extra inputs entry_parity (1 bit, even parity over entry_in) and err_clr (1 bit), and output parity_err (1 bit, sticky).
  - A handshake with a parity mismatch sets parity_err.
  - The write still proceeds.
  - parity_err is cleared by rstn=0 or by err_clr=1. Set has priority if both happen in the same cycle.
- Without the macro: these ports and the logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset/idle: hold rstn=0 for 3 cycles, then release -> all outputs 0, entry_ready=0, no we.
- Full load: load_start with load_offset=1, then 32 back-to-back entries with values e%8 -> 16 we pulses.
  - Page p has bank0=(2p)%8 and bank1=(2p+1)%8.
  - write_addr_offset=1 throughout.
  - load_done one cycle after the page-15 WR; busy returns to 0.
- Backpressure/gaps: entry_valid toggling 1,0,0,1 -> entry_ready stays 1 in COL states, only valid cycles consumed, and we appears exactly 1 cycle after the second handshake.
- Start while busy: assert load_start with load_offset=0 at page 5 -> ignored, write_addr_offset stays 1, page sequence unchanged.
- Reset mid-load: rstn=0 during COL_HI of page 7 -> next cycle IDLE, no we. A new start reloads from page 0.
- Parity (macro defined): entry 0x3 with entry_parity=1 -> parity_err=1 after the handshake and stays 1. err_clr=1 clears it.
